// File: rtl/cartpole_compute.sv
// -----------------------------------------------------------------------------
// cartpole_compute
//
// Batch step engine for the CartPole environment. PE_NUM independent lanes
// each advance a cart-pole state by one Euler step (tau = 0.02 s) for every
// sample accepted on i_ena. Internally the math runs in signed Q8.24 fixed
// point. IEEE-754 single values are converted at the pipeline input and
// converted back at the output.
//
// Pipeline (three register stages, one sample per cycle):
//   S1 : fp32 -> Q8.24 conversion, Taylor sin/cos of theta
//   S2 : force term (temp), angular acceleration (alpha)
//   S3 : linear acceleration, Euler update, termination test, Q8.24 -> fp32
//
// Ports
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous reset, active-high
//   i_ena   : input-valid strobe, all lanes sampled together
//   i_sta   : lane g at [g*128 +: 128] = {x, x_dot, theta, theta_dot} (fp32)
//   i_act   : lane g bit 0, 1 = push right (+10 N), 0 = push left (-10 N)
//   o_sta   : next state, same packing as i_sta
//   o_rwd   : reward per lane
//   o_done  : termination flag per lane
//   o_valid : outputs belong to the sample taken three cycles earlier
//
// Optional feature
//   CARTPOLE_RWD_GATE_EN : when defined, the reward is 0 on a terminating step
//                          (o_rwd = ~o_done); otherwise the reward is always 1.
// -----------------------------------------------------------------------------
module cartpole_compute #(
  parameter int PE_NUM = 20,
  parameter int STA_WL = 128,
  parameter int ACT_WL = 1,
  parameter int RWD_WL = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ena,
  input  logic [PE_NUM*STA_WL-1:0]   i_sta,
  input  logic [PE_NUM*ACT_WL-1:0]   i_act,
  output logic [PE_NUM*STA_WL-1:0]   o_sta,
  output logic [PE_NUM*RWD_WL-1:0]   o_rwd,
  output logic [PE_NUM-1:0]          o_done,
  output logic                       o_valid
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 32;

  // Q8.24 constants (value * 2^24, rounded to nearest)
  localparam logic signed [COEF_W-1:0] C_QMAX    = 32'sh7FFF_FFFF;
  localparam logic signed [COEF_W-1:0] C_QMIN    = 32'sh8000_0001;
  localparam logic signed [COEF_W-1:0] C_ONE     = 32'sd16777216;
  localparam logic signed [COEF_W-1:0] C_TWO     = 32'sd33554432;
  localparam logic signed [COEF_W-1:0] C_INV6    = 32'sd2796203;
  localparam logic signed [COEF_W-1:0] C_INV24   = 32'sd699051;
  localparam logic signed [COEF_W-1:0] C_INV120  = 32'sd139810;
  localparam logic signed [COEF_W-1:0] C_GRAV    = 32'sd164416717;   // 9.8
  localparam logic signed [COEF_W-1:0] C_MPL     = 32'sd838861;      // 0.05
  localparam logic signed [COEF_W-1:0] C_INV_M   = 32'sd15252015;    // 1/1.1
  localparam logic signed [COEF_W-1:0] C_MPL_M   = 32'sd762601;      // 0.05/1.1
  localparam logic signed [COEF_W-1:0] C_MP_M    = 32'sd1525201;     // 0.1/1.1
  localparam logic signed [COEF_W-1:0] C_FOUR3   = 32'sd22369621;    // 4/3
  localparam logic signed [COEF_W-1:0] C_R0      = 32'sd13421773;    // 0.8 seed
  localparam logic signed [COEF_W-1:0] C_FORCE   = 32'sd167772160;   // +10
  localparam logic signed [COEF_W-1:0] C_FORCE_N = -32'sd167772160;  // -10
  localparam logic signed [COEF_W-1:0] C_TAU     = 32'sd335544;      // 0.02
  localparam logic signed [COEF_W-1:0] C_XLIM    = 32'sd40265318;    // 2.4
  localparam logic signed [COEF_W-1:0] C_XLIM_N  = -32'sd40265318;
  localparam logic signed [COEF_W-1:0] C_THLIM   = 32'sd3513812;     // 0.2094395
  localparam logic signed [COEF_W-1:0] C_THLIM_N = -32'sd3513812;

  // Clamp a wide intermediate to the symmetric Q8.24 range.
  function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [63:0] w);
    if (w > 64'sd2147483647)
      return C_QMAX;
    else if (w < -64'sd2147483647)
      return C_QMIN;
    else
      return w[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] add_q(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return sat_q($signed({{32{a[31]}}, a}) + $signed({{32{b[31]}}, b}));
  endfunction

  function automatic logic signed [DATA_W-1:0] sub_q(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return sat_q($signed({{32{a[31]}}, a}) - $signed({{32{b[31]}}, b}));
  endfunction

  // Q8.24 multiply, round half up on the dropped 24 fraction bits.
  function automatic logic signed [DATA_W-1:0] mul_q(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    logic signed [63:0] prod;
    prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod = prod + 64'sd8388608;
    return sat_q(prod >>> 24);
  endfunction

  // fp32 -> Q8.24. The value is mant24 * 2^(e-126) in Q8.24 units, so the
  // exponent directly selects a left or right shift of the 24-bit mantissa.
  // e >= 134 (|v| >= 128), Inf and NaN saturate by sign; tiny values and
  // denormals flush to zero.
  function automatic logic signed [DATA_W-1:0] fp_to_q(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] mag;
    e   = f[30:23];
    mag = 32'd0;
    if (e >= 8'd134)
      mag = 32'h7FFF_FFFF;
    else if (e >= 8'd126)
      mag = {8'd0, 1'b1, f[22:0]} << (e - 8'd126);
    else if (e > 8'd102)
      mag = {8'd0, 1'b1, f[22:0]} >> (8'd126 - e);
    return f[31] ? -$signed(mag) : $signed(mag);
  endfunction

  // Q8.24 -> fp32, normalised, round to nearest even. A mantissa carry-out
  // bumps the exponent and leaves the wrapped mantissa at zero.
  function automatic logic [31:0] q_to_fp(input logic signed [DATA_W-1:0] v);
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  p;
    logic [23:0] rnd;
    logic        round_up;
    logic [7:0]  ex;
    mag = v[31] ? (~v + 32'd1) : v;
    p   = 5'd0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) p = i[4:0];
    norm     = mag << (5'd31 - p);
    round_up = norm[7] & ((|norm[6:0]) | norm[8]);
    rnd      = {1'b0, norm[30:8]} + {23'd0, round_up};
    ex       = {3'd0, p} + 8'd103 + {7'd0, rnd[23]};
    if (mag == 32'd0)
      return 32'd0;
    return {v[31], ex, rnd[22:0]};
  endfunction

  logic vld_p1;
  logic vld_p2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      vld_p1  <= i_ena;
      vld_p2  <= vld_p1;
      o_valid <= vld_p2;
    end
  end

  for (genvar g = 0; g < PE_NUM; g++) begin : g_lane
    logic signed [DATA_W-1:0] x_in, xd_in, th_in, om_in;
    logic signed [DATA_W-1:0] th2, th3, th4, th5, sin_c, cos_c;

    always_comb begin
      x_in  = fp_to_q(i_sta[g*STA_WL+96 +: 32]);
      xd_in = fp_to_q(i_sta[g*STA_WL+64 +: 32]);
      th_in = fp_to_q(i_sta[g*STA_WL+32 +: 32]);
      om_in = fp_to_q(i_sta[g*STA_WL    +: 32]);
      th2   = mul_q(th_in, th_in);
      th3   = mul_q(th2, th_in);
      th4   = mul_q(th2, th2);
      th5   = mul_q(th4, th_in);
      sin_c = add_q(sub_q(th_in, mul_q(th3, C_INV6)), mul_q(th5, C_INV120));
      cos_c = add_q(sub_q(C_ONE, th2 >>> 1), mul_q(th4, C_INV24));
    end

    // ---- S1 register: converted state, sin/cos ----
    logic signed [DATA_W-1:0] x_p1, xd_p1, th_p1, om_p1, sin_p1, cos_p1;
    logic                     act_p1;

    always_ff @(posedge i_clk) begin
      if (i_ena) begin
        x_p1   <= x_in;
        xd_p1  <= xd_in;
        th_p1  <= th_in;
        om_p1  <= om_in;
        sin_p1 <= sin_c;
        cos_p1 <= cos_c;
        act_p1 <= i_act[g*ACT_WL];
      end
    end

    // The denominator 4/3 - mp*cos^2/M stays within [1.24, 1.26] over the
    // operating range, so two Newton steps from 0.8 give a reciprocal far
    // below Q8.24 resolution without a divider. Division by l = 0.5 is a
    // doubling.
    logic signed [DATA_W-1:0] force_c, temp_c, den_c, r1_c, r2_c, num_c, quo_c, alpha_c;

    always_comb begin
      force_c = act_p1 ? C_FORCE : C_FORCE_N;
      temp_c  = mul_q(add_q(force_c, mul_q(C_MPL, mul_q(mul_q(om_p1, om_p1), sin_p1))), C_INV_M);
      den_c   = sub_q(C_FOUR3, mul_q(C_MP_M, mul_q(cos_p1, cos_p1)));
      r1_c    = mul_q(C_R0, sub_q(C_TWO, mul_q(den_c, C_R0)));
      r2_c    = mul_q(r1_c, sub_q(C_TWO, mul_q(den_c, r1_c)));
      num_c   = sub_q(mul_q(C_GRAV, sin_p1), mul_q(cos_p1, temp_c));
      quo_c   = mul_q(num_c, r2_c);
      alpha_c = add_q(quo_c, quo_c);
    end

    // ---- S2 register: state, cos, temp, alpha ----
    logic signed [DATA_W-1:0] x_p2, xd_p2, th_p2, om_p2, cos_p2, temp_p2, alpha_p2;

    always_ff @(posedge i_clk) begin
      if (vld_p1) begin
        x_p2     <= x_p1;
        xd_p2    <= xd_p1;
        th_p2    <= th_p1;
        om_p2    <= om_p1;
        cos_p2   <= cos_p1;
        temp_p2  <= temp_c;
        alpha_p2 <= alpha_c;
      end
    end

    logic signed [DATA_W-1:0] acc_c, xn_c, xdn_c, thn_c, omn_c;
    logic                     done_c;

    always_comb begin
      acc_c  = sub_q(temp_p2, mul_q(C_MPL_M, mul_q(alpha_p2, cos_p2)));
      xn_c   = add_q(x_p2,  mul_q(C_TAU, xd_p2));
      xdn_c  = add_q(xd_p2, mul_q(C_TAU, acc_c));
      thn_c  = add_q(th_p2, mul_q(C_TAU, om_p2));
      omn_c  = add_q(om_p2, mul_q(C_TAU, alpha_p2));
      done_c = (xn_c < C_XLIM_N) | (xn_c > C_XLIM) | (thn_c < C_THLIM_N) | (thn_c > C_THLIM);
    end

    // ---- S3 register: fp32 outputs, held while no new sample arrives ----
    logic [STA_WL-1:0] sta_q;
    logic              done_q;
    logic              rwd_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sta_q  <= '0;
        done_q <= 1'b0;
        rwd_q  <= 1'b0;
      end else if (vld_p2) begin
        sta_q  <= {q_to_fp(xn_c), q_to_fp(xdn_c), q_to_fp(thn_c), q_to_fp(omn_c)};
        done_q <= done_c;
`ifdef CARTPOLE_RWD_GATE_EN
        rwd_q  <= ~done_c;
`else
        rwd_q  <= 1'b1;
`endif
      end
    end

    assign o_sta[g*STA_WL +: STA_WL] = sta_q;
    assign o_done[g]                 = done_q;
    assign o_rwd[g*RWD_WL +: RWD_WL] = RWD_WL'(rwd_q);
  end

endmodule

// File: tb/tb_cartpole_compute.sv
module tb_cartpole_compute;
  localparam int PE = 20;
  localparam int SW = 128;
  localparam real QMAX = 128.0 - 1.0 / 16777216.0;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [PE*SW-1:0]  sta_in;
  logic [PE-1:0]     act_in;
  logic [PE*SW-1:0]  sta_out;
  logic [PE-1:0]     rwd_out;
  logic [PE-1:0]     done_out;
  logic              valid_out;

  always #5 clk = ~clk;

  cartpole_compute #(.PE_NUM(PE), .STA_WL(SW), .ACT_WL(1), .RWD_WL(1)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_ena  (ena),
    .i_sta  (sta_in),
    .i_act  (act_in),
    .o_sta  (sta_out),
    .o_rwd  (rwd_out),
    .o_done (done_out),
    .o_valid(valid_out)
  );

  typedef struct packed {
    logic [PE*SW-1:0] sta;
    logic [PE-1:0]    act;
  } txn_t;

  int               total = 0;
  int               bad   = 0;
  txn_t             q[$];
  bit   [2:0]       sh;
  bit               have_last;
  logic [PE*SW-1:0] last_sta;
  logic [PE-1:0]    last_done;

  function automatic real absr(input real r);
    return (r < 0.0) ? -r : r;
  endfunction

  function automatic real satr(input real r);
    if (r > QMAX) return QMAX;
    if (r < -QMAX) return -QMAX;
    return r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'd0, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic real rr(input real lo, input real hi);
    return lo + (hi - lo) * real'($urandom_range(0, 1000000)) / 1.0e6;
  endfunction

  function automatic logic [127:0] rand_lane();
    return {r2f(rr(-4.8, 4.8)), r2f(rr(-4.0, 4.0)), r2f(rr(-0.42, 0.42)), r2f(rr(-4.0, 4.0))};
  endfunction

  function automatic logic [PE*SW-1:0] rand_vec();
    logic [PE*SW-1:0] v;
    for (int g = 0; g < PE; g++) v[g*SW +: SW] = rand_lane();
    return v;
  endfunction

  // Double-precision reference of one cart-pole Euler step.
  task automatic model(input logic [127:0] s, input logic act,
                       output real xn, output real xdn, output real thn, output real omn,
                       output logic dn, output logic near);
    real x, xd, th, om, sn, cs, f, temp, alpha, acc;
    x     = satr(f2r(s[127:96]));
    xd    = satr(f2r(s[95:64]));
    th    = satr(f2r(s[63:32]));
    om    = satr(f2r(s[31:0]));
    sn    = $sin(th);
    cs    = $cos(th);
    f     = act ? 10.0 : -10.0;
    temp  = (f + 0.05 * om * om * sn) / 1.1;
    alpha = (9.8 * sn - cs * temp) / (0.5 * (4.0 / 3.0 - 0.1 * cs * cs / 1.1));
    acc   = temp - 0.05 * alpha * cs / 1.1;
    xn    = satr(x + 0.02 * xd);
    xdn   = satr(xd + 0.02 * acc);
    thn   = satr(th + 0.02 * om);
    omn   = satr(om + 0.02 * alpha);
    dn    = (xn < -2.4) || (xn > 2.4) || (thn < -0.2094395) || (thn > 0.2094395);
    near  = (absr(absr(xn) - 2.4) < 1.0e-5) || (absr(absr(thn) - 0.2094395) < 1.0e-5);
  endtask

  task automatic chk_val(input string tag, input int lane, input real got, input real exp);
    bit ok;
    ok = absr(got - exp) <= 2.0e-5 + 1.0e-3 * absr(exp);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s lane=%0d observed=%f expected=%f", tag, lane, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input int lane, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s lane=%0d observed=%b expected=%b", tag, lane, got, exp);
    end
  endtask

  task automatic check_txn(input txn_t t);
    real  xn, xdn, thn, omn;
    logic dn, near;
    total++;
    assert (!$isunknown(sta_out) && !$isunknown(done_out) && !$isunknown(rwd_out)) else begin
      bad++;
      $error("FAIL no_x observed=unknown bits expected=known");
    end
    for (int g = 0; g < PE; g++) begin
      model(t.sta[g*SW +: SW], t.act[g], xn, xdn, thn, omn, dn, near);
      chk_val("x",     g, f2r(sta_out[g*SW+96 +: 32]), xn);
      chk_val("x_dot", g, f2r(sta_out[g*SW+64 +: 32]), xdn);
      chk_val("theta", g, f2r(sta_out[g*SW+32 +: 32]), thn);
      chk_val("omega", g, f2r(sta_out[g*SW    +: 32]), omn);
      if (!near) chk_bit("done", g, done_out[g], dn);
`ifdef CARTPOLE_RWD_GATE_EN
      if (!near) chk_bit("rwd", g, rwd_out[g], ~dn);
`else
      chk_bit("rwd", g, rwd_out[g], 1'b1);
`endif
    end
  endtask

  // One clock cycle: drive inputs, step past the edge, check the outputs.
  task automatic cycle(input logic e, input logic [PE*SW-1:0] s, input logic [PE-1:0] a);
    txn_t t;
    ena    = e;
    sta_in = s;
    act_in = a;
    if (e) begin
      t.sta = s;
      t.act = a;
      q.push_back(t);
    end
    @(posedge clk);
    #1;
    sh = {sh[1:0], e};
    chk_bit("valid", -1, valid_out, sh[2]);
    if (sh[2]) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL queue observed=empty expected=pending sample");
      end else begin
        check_txn(q.pop_front());
      end
      last_sta  = sta_out;
      last_done = done_out;
      have_last = 1'b1;
    end else if (have_last) begin
      total++;
      assert (sta_out === last_sta && done_out === last_done) else begin
        bad++;
        $error("FAIL hold observed=changed expected=held outputs");
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    #1;
    total++;
    assert (valid_out === 1'b0 && sta_out === '0 && done_out === '0 && rwd_out === '0) else begin
      bad++;
      $error("FAIL reset observed=valid:%b done:%h rwd:%h expected=all zero",
             valid_out, done_out, rwd_out);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    sh        = '0;
    last_sta  = '0;
    last_done = '0;
    have_last = 1'b1;
  endtask

  initial begin
    logic [PE*SW-1:0] v;
    logic [PE-1:0]    a;

    ena    = 1'b0;
    sta_in = '0;
    act_in = '0;
    sh     = '0;
    have_last = 1'b0;
    do_reset();
    idle(2);

    // Reference lanes from the test plan, other lanes random
    v = rand_vec();
    a = PE'($urandom);
    v[0*SW +: SW] = {32'h3cc7d5cf, 32'h3c263435, 32'hbc9b0897, 32'hbd2e64b9};
    a[0] = 1'b0;
    v[1*SW +: SW] = {32'hbbff9862, 32'h3c647ed6, 32'hbc80d245, 32'hbd4ace32};
    a[1] = 1'b1;
    cycle(1'b1, v, a);
    idle(3);
    chk_val("plan_x",     0, f2r(sta_out[96 +: 32]),  0.0245968);
    chk_val("plan_x_dot", 0, f2r(sta_out[64 +: 32]), -0.184701);
    chk_val("plan_theta", 0, f2r(sta_out[32 +: 32]), -0.0197765);
    chk_val("plan_omega", 0, f2r(sta_out[0  +: 32]),  0.244076);
    chk_val("plan_x",     1, f2r(sta_out[SW+96 +: 32]), -0.00752122);
    chk_val("plan_x_dot", 1, f2r(sta_out[SW+64 +: 32]),  0.209290);
    chk_val("plan_theta", 1, f2r(sta_out[SW+32 +: 32]), -0.0167155);
    chk_val("plan_omega", 1, f2r(sta_out[SW    +: 32]), -0.347116);
    idle(2);

    // Boundary and saturation lanes
    v = rand_vec();
    a = PE'($urandom);
    v[0*SW +: SW] = {r2f(2.39), r2f(1.0),  32'd0, 32'd0};
    a[0] = 1'b1;
    v[1*SW +: SW] = {r2f(2.39), r2f(0.25), 32'd0, 32'd0};
    v[2*SW +: SW] = {32'd0, 32'd0, r2f(0.21), 32'd0};
    v[3*SW +: SW] = {32'h49742400, r2f(0.5), r2f(0.1), r2f(-0.3)};
    cycle(1'b1, v, a);
    idle(3);
    chk_val("bnd_x",  0, f2r(sta_out[0*SW+96 +: 32]), 2.41);
    chk_bit("bnd_done", 0, done_out[0], 1'b1);
    chk_val("bnd_x",  1, f2r(sta_out[1*SW+96 +: 32]), 2.395);
    chk_bit("bnd_done", 1, done_out[1], 1'b0);
    chk_bit("bnd_done", 2, done_out[2], 1'b1);
    chk_val("sat_x",  3, f2r(sta_out[3*SW+96 +: 32]), 128.0);
    chk_bit("sat_done", 3, done_out[3], 1'b1);
    idle(1);

    // Back-to-back throughput
    for (int i = 0; i < 10; i++) cycle(1'b1, rand_vec(), PE'($urandom));
    idle(4);

    // Reset one cycle after an accepted sample discards it
    cycle(1'b1, rand_vec(), PE'($urandom));
    do_reset();
    idle(4);

    // Reset while idle after real outputs
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_vec(), PE'($urandom));
    idle(4);
    do_reset();
    idle(2);

    // Isolated pulses with random gaps
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, rand_vec(), PE'($urandom));
      idle($urandom_range(0, 4));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
